// File: rtl/ucom_timer_pkg.sv
// ============================================================================
// Module : ucom_timer_pkg
// Brief  : Shared constants and helpers for the uCOM-4x timer/interrupt block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ucom_timer_pkg;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam int VEC_EXT = 0;

  // Channel-select width; a single channel still gets a 1-bit select port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ucom_timer_chan.sv
// ============================================================================
// Module : ucom_timer_chan
// Brief  : One interval-timer channel: prescaler, down-counter, reload and TM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ucom_timer_chan
  import ucom_timer_pkg::*;
#(
  parameter int PRE_W = 6,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  input  logic             ld_mode_i,
  input  logic             clr_i,
  output logic             tm_o,
  output logic             fire_o
);

  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tm_q, tm_d;
  logic             w_run;
  logic             w_wrap;
  logic             w_fire;

  assign w_run  = ~tm_q | (mode_q == MODE_RELOAD);
  assign w_wrap = &pcnt_q;
  // A same-tick load suppresses the timeout event entirely.
  assign w_fire = tick_en_i & w_run & w_wrap & (bcnt_q == '0) & ~ld_i;

  always_comb begin
    pcnt_d   = pcnt_q;
    bcnt_d   = bcnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tm_d     = tm_q;
    if (tick_en_i) begin
      if (ld_i) begin
        pcnt_d   = '0;
        bcnt_d   = ld_val_i;
        reload_d = ld_val_i;
        mode_d   = ld_mode_i;
        tm_d     = 1'b0;
      end else begin
        if (w_run) begin
          pcnt_d = pcnt_q + 1'b1;
          if (w_wrap) begin
            if (bcnt_q == '0) begin
              tm_d   = 1'b1;
              bcnt_d = (mode_q == MODE_RELOAD) ? reload_q : bcnt_q - 1'b1;
            end else begin
              bcnt_d = bcnt_q - 1'b1;
            end
          end
        end
        if (clr_i && !w_fire) begin
          tm_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt_q   <= '0;
      bcnt_q   <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      tm_q     <= 1'b1;
    end else begin
      pcnt_q   <= pcnt_d;
      bcnt_q   <= bcnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tm_q     <= tm_d;
    end
  end

  assign tm_o   = tm_q;
  assign fire_o = w_fire;

endmodule

`default_nettype wire

// File: rtl/ucom_timer_irq.sv
// ============================================================================
// Module : ucom_timer_irq
// Brief  : Multi-channel interval timer with prioritised, maskable interrupt.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ucom_timer_irq
  import ucom_timer_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int PRE_W       = 6,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick_en,
  input  logic                         ld,
  input  logic [idx_w(CHANNELS)-1:0]   ld_ch,
  input  logic [CNT_W-1:0]             ld_val,
  input  logic                         ld_mode,
  input  logic                         tst,
  input  logic                         tst_clr,
  input  logic [idx_w(CHANNELS)-1:0]   tst_ch,
  output logic                         tst_hit,
  output logic [CHANNELS-1:0]          tm,
  input  logic                         int_n,
  input  logic [CHANNELS-1:0]          ch_ie,
  input  logic                         ien_set,
  input  logic                         ien_clr,
  input  logic                         tit,
  output logic                         tit_hit,
  output logic                         irq,
  output logic [3:0]                   irq_vec,
  input  logic                         irq_ack
);

  localparam int IDX_W = idx_w(CHANNELS);
  localparam int NSRC  = CHANNELS + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   edge_hold_q, edge_hold_d;
  logic                   w_edge_now;
  logic                   w_edge_any;

  logic [CHANNELS-1:0]    w_fire;
  logic [CHANNELS-1:0]    w_ld_sel;
  logic [CHANNELS-1:0]    w_clr_sel;
  logic                   w_ld_ok;
  logic                   w_tst_valid;
  logic                   w_tm_sel;
  logic                   w_ack;
  logic [NSRC-1:0]        w_pend;
  logic [NSRC-1:0]        w_ack_clr;
  logic [3:0]             w_prio;

  logic [CHANNELS-1:0]    ch_pend_q, ch_pend_d;
  logic                   ext_pend_q, ext_pend_d;
  logic                   ien_q, ien_d;
  logic                   irq_q, irq_d;
  logic [3:0]             irq_vec_q, irq_vec_d;
  logic                   tst_hit_q, tst_hit_d;
  logic                   tit_hit_q, tit_hit_d;

  // Synchronizer and falling-edge capture run every clk; a captured edge is
  // parked in edge_hold_q until the next machine-cycle strobe consumes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q      <= '1;
      sync_prev_q <= 1'b1;
      edge_hold_q <= 1'b0;
    end else begin
      sync_q      <= SYNC_STAGES'({sync_q, int_n});
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      edge_hold_q <= edge_hold_d;
    end
  end

  assign w_edge_now  = sync_prev_q & ~sync_q[SYNC_STAGES-1];
  assign w_edge_any  = w_edge_now | edge_hold_q;
  assign edge_hold_d = tick_en ? 1'b0 : w_edge_any;

  assign w_ld_ok     = ld & tick_en & (32'(ld_ch) < CHANNELS);
  assign w_tst_valid = 32'(tst_ch) < CHANNELS;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign w_ld_sel[k]  = w_ld_ok & (ld_ch == IDX_W'(k));
    assign w_clr_sel[k] = tst & tst_clr & tick_en & w_tst_valid & (tst_ch == IDX_W'(k));

    ucom_timer_chan #(
      .PRE_W (PRE_W),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .tick_en_i (tick_en),
      .ld_i      (w_ld_sel[k]),
      .ld_val_i  (ld_val),
      .ld_mode_i (ld_mode),
      .clr_i     (w_clr_sel[k]),
      .tm_o      (tm[k]),
      .fire_o    (w_fire[k])
    );
  end

  always_comb begin
    w_tm_sel = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (tst_ch == IDX_W'(k)) begin
        w_tm_sel = tm[k];
      end
    end
  end

  assign w_pend = {ch_pend_q, ext_pend_q};

  always_comb begin
    w_prio = 4'(VEC_EXT);
    for (int s = NSRC - 1; s >= 0; s--) begin
      if (w_pend[s]) begin
        w_prio = 4'(s);
      end
    end
  end

  assign w_ack     = tick_en & irq_ack & irq_q;
  assign w_ack_clr = w_ack ? (NSRC'(1) << irq_vec_q) : '0;

  // New events are OR-ed in after the clears so a re-firing source survives
  // an acknowledge or test-and-clear in the same cycle.
  always_comb begin
    ch_pend_d  = ch_pend_q;
    ext_pend_d = ext_pend_q;
    ien_d      = ien_q;
    irq_d      = irq_q;
    irq_vec_d  = irq_vec_q;
    tst_hit_d  = tst_hit_q;
    tit_hit_d  = tit_hit_q;
    if (tick_en) begin
      {ch_pend_d, ext_pend_d} = w_pend & ~w_ack_clr;
      if (tit) begin
        tit_hit_d  = ext_pend_q;
        ext_pend_d = 1'b0;
      end
      ext_pend_d = ext_pend_d | w_edge_any;
      ch_pend_d  = ch_pend_d | (w_fire & ch_ie);
      if (ien_set) ien_d = 1'b1;
      if (ien_clr) ien_d = 1'b0;
      if (w_ack)   ien_d = 1'b0;
      if (tst) begin
        tst_hit_d = w_tst_valid & w_tm_sel;
      end
      irq_d = ien_q & (|w_pend);
      if (irq_d) begin
        irq_vec_d = w_prio;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_pend_q  <= '0;
      ext_pend_q <= 1'b0;
      ien_q      <= 1'b0;
      irq_q      <= 1'b0;
      irq_vec_q  <= 4'(VEC_EXT);
      tst_hit_q  <= 1'b0;
      tit_hit_q  <= 1'b0;
    end else begin
      ch_pend_q  <= ch_pend_d;
      ext_pend_q <= ext_pend_d;
      ien_q      <= ien_d;
      irq_q      <= irq_d;
      irq_vec_q  <= irq_vec_d;
      tst_hit_q  <= tst_hit_d;
      tit_hit_q  <= tit_hit_d;
    end
  end

  assign tst_hit = tst_hit_q;
  assign tit_hit = tit_hit_q;
  assign irq     = irq_q;
  assign irq_vec = irq_vec_q;

endmodule

`default_nettype wire

// File: doc/ucom_timer_irq.md
Name: ucom_timer_irq

Overview:
Parametrised multi-channel interval timer and interrupt controller for the uCOM-4x family of MCU cores. It replaces the single hard-wired 6+6-bit timer, TM flag and single-source interrupt latch. It provides N independently loadable channels with one-shot or auto-reload modes, test-and-clear flags, and a prioritised, maskable interrupt request with vector output. The MCU core drives it from its instruction decode, using one tick_en strobe per machine cycle.

Parameters:
CHANNELS, 2, number of timer channels (1..8)
PRE_W, 6, prescaler width; one prescale period is 2^PRE_W ticks
CNT_W, 6, binary down-counter width
SYNC_STAGES, 2, synchronizer depth for int_n

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick_en  in  1  machine-cycle strobe; all state except the int_n synchronizer advances only when high
ld  in  1  load strobe (STM equivalent)
ld_ch  in  max(1,$clog2(CHANNELS))  channel being loaded
ld_val  in  CNT_W  count value
ld_mode  in  1  0 = one-shot, 1 = auto-reload
tst  in  1  test strobe (TTM equivalent)
tst_clr  in  1  with tst, clear the tested flag
tst_ch  in  max(1,$clog2(CHANNELS))  channel being tested
tst_hit  out  1  registered flag value from the last test
tm  out  CHANNELS  per-channel timeout flags
int_n  in  1  external interrupt, active-low, asynchronous
ch_ie  in  CHANNELS  per-channel interrupt source enable
ien_set  in  1  global enable set (EI)
ien_clr  in  1  global enable clear (DI)
tit  in  1  test-and-clear external pending
tit_hit  out  1  registered external-pending value at tit
irq  out  1  interrupt request to the core
irq_vec  out  4  index of the highest-priority pending source: 0 = external, 1+k = channel k
irq_ack  in  1  core is taking the interrupt

Behaviour:
- Reset (reset==0 at a clk edge): all counters 0; tm all 1 (stopped); modes 0; reload 0; ien 0; all pending 0; tst_hit, tit_hit, irq 0; irq_vec 0. The synchronizer flops reset to 1.
- Reset takes priority over every strobe. A reset in mid-count abandons the count; no flag or pending bit survives.
- Channel count rule (per tick_en, channel running = ~tm or mode==1):
  - pcount increments and wraps.
  - When pcount is all ones:
    - if bcount==0, set tm; bcount reloads in auto-reload mode, otherwise decrements (wraps, then holds because the channel stops).
    - otherwise bcount decrements.
  - Timeout period = (ld_val+1)*2^PRE_W ticks after the load tick.
- Load (ld & tick_en): the selected channel gets pcount=0, bcount=reload=ld_val, mode=ld_mode, tm=0. A load overrides a same-cycle count or timeout on that channel. Other channels are unaffected.
- Test (tst & tick_en): tst_hit <= tm[tst_ch] on the next edge.
  - If tst_clr is also high, tm[tst_ch] clears, except when the same cycle sets it (set wins).
  - tst and ld may target different channels in the same cycle. If they target the same channel, tst_hit reflects the pre-load flag.
- Pending sources:
  - ext_pend sets on a synchronized int_n 1->0 edge. The edge is detected every clk, held until tick_en, and never lost.
  - ch_pend[k] sets on the tick where tm[k] rises (or re-fires in auto-reload) and ch_ie[k]==1.
- tit & tick_en: tit_hit <= ext_pend; ext_pend clears. A same-cycle new edge wins and stays pending.
- Enable: ien_set and ien_clr both high means ien_clr wins.
- irq = ien & |{ch_pend, ext_pend}, registered (1-cycle latency). irq_vec is the lowest index pending, registered alongside irq, and held while irq==0.
- irq_ack & tick_en: clear the pending bit selected by irq_vec and clear ien (the core re-enables with EI after the handler). irq falls on the following edge.
  - irq_ack with irq==0 is ignored.
  - A source that re-fires in the ack cycle stays pending.
- ld_ch/tst_ch >= CHANNELS: the operation is ignored; tst_hit <= 0.

Decomposition:
- Package ucom_timer_pkg holds:
  - MODE_ONESHOT and MODE_RELOAD constants
  - the VEC_EXT=0 constant
  - a function computing the index width from CHANNELS
- One sub-module, ucom_timer_chan, contains the prescaler, counter, reload, mode and tm flag. The top instantiates it CHANNELS times (generate). The top owns the synchronizer, pending logic, priority encoder, enable and test muxes.

Test Plan:
- Defaults, tick_en every cycle, load ch0 ld_val=3 one-shot -> tm[0] rises exactly after the 256th tick following the load, stays 1, and counters freeze.
- ch1 ld_val=0 auto-reload, ch_ie=2'b10, ien_set -> tm[1] at 64 ticks; irq=1 with irq_vec=2 one cycle later; irq_ack clears irq and ien; the next ch_pend arrives 64 ticks later and irq stays 0 until ien_set.
- tst with tst_clr on ch0 in the exact tick tm[0] sets -> tst_hit=0 and tm[0] remains 1. Repeating the test gives tst_hit=1, then tm[0]=0.
- int_n pulse low for 1 clk while tick_en is low for 5 cycles, ien=1 -> ext_pend latched; irq=1 with irq_vec=0. With ch0 pending at the same time, vec stays 0 until acked, then shows 1.
- Reload of ch0 (ld_val=5) mid-count at pcount=40 -> pcount restarts at 0 and timeout lands 384 ticks after the second load.
- Drive reset low mid-count with pending irq -> next cycle tm all 1, irq=0, ien=0; after release no spurious irq with int_n held high.
